if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage that produces if_pc/if_inst for the IF/ID pipeline register.
//  Owns the PC and fetches each instruction from the instruction bus over a req/ack handshake.
//  Requests a pipeline stall from ctrl while a fetch is outstanding.
//  Tracks branch redirects (MIPS delay slot preserved) and exception flushes.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  ADDR_W    32             PC / bus address width
//  DATA_W    32             instruction width
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous reset, active-high (`RstEnable)
//  stall            in   6       ctrl stall vector; bit0 = PC stage (`STOP=1)
//  branch_flag_i    in   1       one-cycle pulse from ID: branch taken
//  branch_target_i  in   ADDR_W  branch target, valid with branch_flag_i
//  flush_i          in   1       one-cycle pulse: exception flush
//  new_pc_i         in   ADDR_W  exception handler PC, valid with flush_i
//  ibus_req         out  1       fetch request
//  ibus_addr        out  ADDR_W  fetch address
//  ibus_ack         in   1       slave ack; ibus_rdata valid this cycle
//  ibus_rdata       in   DATA_W  fetched instruction
//  stallreq_from_if out  1       stall request to ctrl
//  if_pc            out  ADDR_W  PC of presented instruction (0 when none)
//  if_inst          out  DATA_W  presented instruction (0 = bubble)
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, buffer=0, br_pend=0. ibus_req=0, ibus_addr=pc,
//    stallreq_from_if=0, if_pc=0, if_inst=0. Reset aborts any outstanding fetch.
//  FSM states:
//   IDLE : one cycle after reset; next -> REQ.
//   REQ  : ibus_req=1, ibus_addr=pc, stallreq_from_if=1, if_pc=if_inst=0.
//          ibus_ack=1 -> buffer<=ibus_rdata, go to VALID.
//   VALID: ibus_req=0, stallreq_from_if=0, if_pc=pc, if_inst=buffer.
//          stall[0]=1 -> hold all state and outputs.
//          stall[0]=0 -> pc<=next_pc, go to REQ.
//   DRAIN: flush pending. ibus_req=1 held, stallreq_from_if=1, outputs 0.
//          ibus_ack=1 -> discard data, go to REQ (pc already = new_pc_i).
//  next_pc = br_pend ? br_target : pc+4. Clear br_pend when it is consumed.
//    Add modulo 2^ADDR_W; wraps silently.
//  Branch pulse in any state: br_target<=branch_target_i, br_pend<=1. The fetch in flight,
//    or the buffered instruction, is the delay slot and is still delivered.
//    Same-cycle VALID advance uses branch_target_i directly.
//  Flush pulse (priority over branch, clears br_pend):
//    in REQ without ack        -> pc<=new_pc_i, go to DRAIN.
//    in REQ with ack, or VALID -> pc<=new_pc_i, drop buffer, go to REQ.
//    in IDLE                   -> pc<=new_pc_i.
//  Bus rules:
//    - ibus_req/ibus_addr stay stable from assertion until the ack cycle.
//    - Ack is accepted in the same cycle req rises (zero-wait).
//    - Ack while ibus_req=0 is ignored.
//    - ibus_req deasserts the cycle after ack.
//  Latency: zero-wait slave gives one instruction per 2 cycles (REQ, VALID).
//  Outputs are decoded from registered state only; no combinational path from ibus_ack.
// TESTING
//  1 Reset, RESET_PC=0, zero-wait slave returns addr+0x100 -> ibus_addr 0,4,8 in REQ cycles;
//    if_inst=0x100,0x104,0x108 with if_pc=0,4,8 in VALID cycles.
//  2 Ack delayed 3 cycles at addr 0x4 -> req/addr stable 4 cycles; stallreq_from_if=1
//    and if_inst=0 throughout; VALID follows with pc 0x4.
//  3 stall[0]=1 for 2 cycles in VALID at pc 0x8 -> if_pc/if_inst held, ibus_req=0;
//    next REQ addr 0xC.
//  4 branch_flag_i pulse, target 0x100, during REQ for 0x8 -> 0x8 delivered (delay slot);
//    next ibus_addr 0x100, never 0xC.
//  5 flush_i, new_pc 0x20, during unacked REQ 0x10 -> DRAIN; its ack data never appears
//    on if_inst; next REQ addr 0x20; a branch pulse in the same cycle is ignored.
//  6 rst high in a REQ wait state -> next cycle ibus_req=0, outputs 0; then REQ at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus and presents
// if_pc/if_inst to IF/ID, honouring delay-slot branches and exception flushes.
module if_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_ack,
  input  logic [DATA_W-1:0] ibus_rdata,
  output logic              stallreq_from_if,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              br_pend_q, br_pend_d;
  logic [ADDR_W-1:0] br_target_q, br_target_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [ADDR_W-1:0] next_pc;

  // Only the PC-stage bit of the ctrl stall vector concerns this stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // A branch seen in the same cycle the VALID stage advances wins over anything pending.
  assign next_pc = branch_flag_i ? branch_target_i
                 : (br_pend_q    ? br_target_q : pc_q + ADDR_W'(4));

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    br_pend_d    = br_pend_q;
    br_target_d  = br_target_q;
    drain_addr_d = drain_addr_q;

    if (branch_flag_i) begin
      br_target_d = branch_target_i;
      br_pend_d   = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (flush_i) begin
          pc_d      = new_pc_i;
          br_pend_d = 1'b0;
        end
      end
      S_REQ: begin
        if (flush_i) begin
          pc_d      = new_pc_i;
          br_pend_d = 1'b0;
          if (ibus_ack) begin
            buf_d   = '0;
            state_d = S_REQ;
          end else begin
            // The bus must see the old address until the slave acks it.
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end else if (ibus_ack) begin
          buf_d   = ibus_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (flush_i) begin
          pc_d      = new_pc_i;
          br_pend_d = 1'b0;
          buf_d     = '0;
          state_d   = S_REQ;
        end else if (!stall[0]) begin
          pc_d      = next_pc;
          br_pend_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_DRAIN: begin
        if (flush_i) begin
          pc_d      = new_pc_i;
          br_pend_d = 1'b0;
        end
        if (ibus_ack) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      buf_q        <= '0;
      br_pend_q    <= 1'b0;
      br_target_q  <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_q        <= buf_d;
      br_pend_q    <= br_pend_d;
      br_target_q  <= br_target_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign ibus_req         = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign stallreq_from_if = ibus_req;
  assign ibus_addr        = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign if_pc            = (state_q == S_VALID) ? pc_q  : '0;
  assign if_inst          = (state_q == S_VALID) ? buf_q : '0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a queue-based scoreboard checks every accepted bus
// address and every presented instruction; directed checks cover reset, stall, drain.
module tb_if_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        stallreq_from_if;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_delay = 0;

  logic [31:0] exp_addr[$];
  out_t        exp_out[$];

  if_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_flag_i    (branch_flag_i),
    .branch_target_i  (branch_target_i),
    .flush_i          (flush_i),
    .new_pc_i         (new_pc_i),
    .ibus_req         (ibus_req),
    .ibus_addr        (ibus_addr),
    .ibus_ack         (ibus_ack),
    .ibus_rdata       (ibus_rdata),
    .stallreq_from_if (stallreq_from_if),
    .if_pc            (if_pc),
    .if_inst          (if_inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic push_fetch(input logic [31:0] pc);
    out_t o;
    o.pc   = pc;
    o.inst = pc + 32'h100;
    exp_addr.push_back(pc);
    exp_out.push_back(o);
  endtask

  // Returns on the falling edge where the instruction at pc is presented.
  task automatic wait_valid(input logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (if_inst != 0 && if_pc == pc) found = 1;
    end
    check("wait_valid_timeout", {31'd0, found}, 32'd1);
  endtask

  // Slave: acks after ack_delay wait cycles, data = addr + 0x100; driven just after the edge.
  initial begin
    int waited = 0;
    ibus_ack   = 1'b0;
    ibus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ibus_req) begin
        if (waited >= ack_delay) begin
          ibus_ack   = 1'b1;
          ibus_rdata = ibus_addr + 32'h100;
          waited     = 0;
        end else begin
          ibus_ack = 1'b0;
          waited++;
        end
      end else begin
        ibus_ack = 1'b0;
        waited   = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes a fetch or presents an instruction.
  initial begin
    logic [31:0] prev_inst = '0;
    forever begin
      @(negedge clk);
      if (ibus_req && ibus_ack) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          $display("FAIL bus_addr: unexpected fetch of 0x%08h, expected none", ibus_addr);
        end else begin
          check("bus_addr", ibus_addr, exp_addr.pop_front());
        end
      end
      if (if_inst != 0 && prev_inst == 0) begin
        if (exp_out.size() == 0) begin
          n_checks++;
          $display("FAIL if_out: unexpected inst 0x%08h at pc 0x%08h, expected none", if_inst, if_pc);
        end else begin
          out_t o;
          o = exp_out.pop_front();
          check("if_pc", if_pc, o.pc);
          check("if_inst", if_inst, o.inst);
        end
      end
      prev_inst = if_inst;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable_ok;
    int req_cycles;

    rst = 1'b1; stall = 6'd0; branch_flag_i = 1'b0; branch_target_i = '0;
    flush_i = 1'b0; new_pc_i = '0;

    // Reset state and zero-wait streaming 0,4,8.
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, ibus_req}, 32'd0);
    check("rst_stallreq", {31'd0, stallreq_from_if}, 32'd0);
    check("rst_addr", ibus_addr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h8);
    rst = 1'b0;
    wait_valid(32'h8);
    stall = 6'b000001;

    // Stall holds VALID at 0x8, then the next fetch is 0xC.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_if_pc", if_pc, 32'h8);
      check("stall_if_inst", if_inst, 32'h108);
      check("stall_req", {31'd0, ibus_req}, 32'd0);
    end
    push_fetch(32'hC);
    stall = 6'd0;
    wait_valid(32'hC);
    stall = 6'b000001;

    // Reset during a REQ wait state at 0x10.
    @(negedge clk);
    ack_delay = 5; stall = 6'd0;
    @(negedge clk);
    check("wait_req", {31'd0, ibus_req}, 32'd1);
    check("wait_addr", ibus_addr, 32'h10);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_req", {31'd0, ibus_req}, 32'd0);
    check("rst2_if_inst", if_inst, 32'h0);
    check("rst2_addr", ibus_addr, 32'h0);
    push_fetch(32'h0); push_fetch(32'h4);
    ack_delay = 0; rst = 1'b0;

    // Ack delayed 3 cycles at 0x4: request held and stable for 4 cycles.
    wait_valid(32'h0);
    ack_delay = 3;
    stable_ok = 1; req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ibus_req) break;
      if (ibus_addr != 32'h4 || !stallreq_from_if || if_inst != 0) stable_ok = 0;
      req_cycles++;
    end
    stall = 6'b000001; ack_delay = 2;
    check("delay_stable", {31'd0, stable_ok}, 32'd1);
    check("delay_cycles", req_cycles, 32'd4);

    // Branch to 0x100 during REQ 0x8: 0x8 is the delay slot, 0xC never fetched.
    @(negedge clk);
    push_fetch(32'h8); push_fetch(32'h100);
    stall = 6'd0;
    @(negedge clk);
    check("br_req_addr", ibus_addr, 32'h8);
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    @(negedge clk);
    branch_flag_i = 1'b0;
    wait_valid(32'h100);
    stall = 6'b000001;

    // Flush from VALID to 0x10, then flush to 0x20 during unacked REQ 0x10 with a branch.
    @(negedge clk);
    ack_delay = 3;
    exp_addr.push_back(32'h10);
    push_fetch(32'h20);
    flush_i = 1'b1; new_pc_i = 32'h10;
    @(negedge clk);
    check("fl_valid_inst", if_inst, 32'h0);
    check("fl_req_addr", ibus_addr, 32'h10);
    new_pc_i = 32'h20; branch_flag_i = 1'b1; branch_target_i = 32'h300;
    @(negedge clk);
    flush_i = 1'b0; branch_flag_i = 1'b0;
    check("drain_req", {31'd0, ibus_req}, 32'd1);
    check("drain_addr", ibus_addr, 32'h10);
    check("drain_stallreq", {31'd0, stallreq_from_if}, 32'd1);
    wait_valid(32'h20);
    push_fetch(32'h24);
    stall = 6'd0;
    wait_valid(32'h24);
    stall = 6'b000001;

    repeat (3) @(negedge clk);
    check("addr_queue_empty", exp_addr.size(), 32'd0);
    check("out_queue_empty", exp_out.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
